lifo_multi_ch: RTL and testbench

- Multi-channel stack buffer: CH independent LIFOs of DEPTH entries each, sharing one push port and one pop port. Each port carries a channel select.
- Successor to the single-stack LIFO. Adds per-channel stacks, per-channel flush, registered pop data with a valid strobe, replace-top on simultaneous push/pop, and almost-full/almost-empty thresholds.
- Sits between a multi-context producer (e.g. per-thread return addresses or descriptors) and a consumer that pops by context.

---
 rtl/lifo_multi_ch.sv | 131 +++++++++++++
 tb/tb_lifo_multi_ch.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lifo_multi_ch.sv
// Multi-channel LIFO: CH independent stacks of DEPTH words behind one push and one pop port.
// Same-channel push+pop replaces the top; a flush wins over same-channel traffic silently.
module lifo_multi_ch #(
    parameter int CH      = 4,
    parameter int DEPTH   = 8,
    parameter int DATA_W  = 32,
    parameter int AF_LVL  = DEPTH - 2,
    parameter int AE_LVL  = 2,
    localparam int CH_W    = (CH > 1) ? $clog2(CH) : 1,
    localparam int DEPTH_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  w_req,
    input  logic [CH_W-1:0]       w_ch,
    input  logic [DATA_W-1:0]     w_data,
    input  logic                  r_req,
    input  logic [CH_W-1:0]       r_ch,
    output logic [DATA_W-1:0]     r_data,
    output logic                  r_valid,
    input  logic                  clr,
    input  logic [CH_W-1:0]       clr_ch,
    output logic [CH*DEPTH_W-1:0] cnt,
    output logic [CH-1:0]         empty,
    output logic [CH-1:0]         full,
    output logic [CH-1:0]         almost_empty,
    output logic [CH-1:0]         almost_full,
    output logic                  fail
);

    localparam int A_W = $clog2(DEPTH);

    localparam logic [CH_W:0]      CH_LIM  = (CH_W+1)'(CH);
    localparam logic [DEPTH_W-1:0] DEPTH_C = DEPTH_W'(DEPTH);
    localparam logic [DEPTH_W-1:0] AF_C    = DEPTH_W'(AF_LVL);
    localparam logic [DEPTH_W-1:0] AE_C    = DEPTH_W'(AE_LVL);
    localparam logic [DEPTH_W-1:0] ONE     = DEPTH_W'(1);

    logic [DATA_W-1:0]  mem_q [CH][DEPTH];
    logic [DEPTH_W-1:0] cnt_q [CH];
    logic [DEPTH_W-1:0] cnt_d [CH];
    logic [DATA_W-1:0]  r_data_q, r_data_d;
    logic               r_valid_q, r_valid_d;
    logic               fail_q, fail_d;

    logic               w_ok, r_ok, clr_ok;
    logic               w_flush, r_flush;
    logic [CH_W-1:0]    w_idx, r_idx;
    logic [DEPTH_W-1:0] w_cnt, r_cnt;
    logic               pop_acc, push_acc, replace;
    logic [A_W-1:0]     w_addr, r_addr;
    logic [DATA_W-1:0]  rd_word;

    // Out-of-range selects are steered to channel 0 so no array access goes out of bounds;
    // the accept terms below already exclude them.
    always_comb begin
        w_ok    = ({1'b0, w_ch} < CH_LIM);
        r_ok    = ({1'b0, r_ch} < CH_LIM);
        clr_ok  = clr && ({1'b0, clr_ch} < CH_LIM);
        w_idx   = w_ok ? w_ch : '0;
        r_idx   = r_ok ? r_ch : '0;
        w_cnt   = cnt_q[w_idx];
        r_cnt   = cnt_q[r_idx];
        w_flush = clr_ok && (clr_ch == w_ch);
        r_flush = clr_ok && (clr_ch == r_ch);

        pop_acc  = r_req && r_ok && !r_flush && (r_cnt != '0);
        replace  = pop_acc && w_req && w_ok && (w_ch == r_ch);
        push_acc = w_req && w_ok && !w_flush && (replace || (w_cnt != DEPTH_C));

        fail_d   = (w_req && !w_flush && !push_acc) || (r_req && !r_flush && !pop_acc);

        w_addr   = replace ? A_W'(w_cnt - ONE) : A_W'(w_cnt);
        r_addr   = A_W'(r_cnt - ONE);
        rd_word  = mem_q[r_idx][r_addr];

        r_valid_d = pop_acc;
        r_data_d  = pop_acc ? rd_word : r_data_q;
    end

    always_comb begin
        for (int k = 0; k < CH; k++) begin
            cnt_d[k] = cnt_q[k];
            if (clr_ok && (clr_ch == CH_W'(k))) begin
                cnt_d[k] = '0;
            end else if (!replace) begin
                if (push_acc && (w_idx == CH_W'(k))) cnt_d[k] = cnt_d[k] + ONE;
                if (pop_acc && (r_idx == CH_W'(k)))  cnt_d[k] = cnt_d[k] - ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int k = 0; k < CH; k++) cnt_q[k] <= '0;
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            for (int k = 0; k < CH; k++) cnt_q[k] <= cnt_d[k];
            r_data_q  <= r_data_d;
            r_valid_q <= r_valid_d;
            fail_q    <= fail_d;
        end
    end

    // Storage is never reset; only the counts define what is live.
    always_ff @(posedge clk) begin
        if (push_acc) mem_q[w_idx][w_addr] <= w_data;
    end

    always_comb begin
        cnt          = '0;
        empty        = '0;
        full         = '0;
        almost_empty = '0;
        almost_full  = '0;
        for (int k = 0; k < CH; k++) begin
            cnt[k*DEPTH_W +: DEPTH_W] = cnt_q[k];
            empty[k]        = (cnt_q[k] == '0);
            full[k]         = (cnt_q[k] == DEPTH_C);
            almost_empty[k] = (cnt_q[k] <= AE_C);
            almost_full[k]  = (cnt_q[k] >= AF_C);
        end
    end

    assign r_data  = r_data_q;
    assign r_valid = r_valid_q;
    assign fail    = fail_q;

endmodule

// File: tb/tb_lifo_multi_ch.sv
// Scoreboard bench for lifo_multi_ch: a queue-based stack model predicts pops and status,
// a negedge monitor compares whatever the DUT presents.
module tb_lifo_multi_ch;

    localparam int NCH = 5;
    localparam int DEP = 8;
    localparam int DW  = 32;
    localparam int AF  = 6;
    localparam int AE  = 2;
    localparam int CW  = 3;
    localparam int DPW = 4;

    typedef struct packed {
        logic [NCH*DPW-1:0] cnt;
        logic               fail;
        logic               rv;
    } st_t;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic              w_req = 1'b0, r_req = 1'b0, clr = 1'b0;
    logic [CW-1:0]     w_ch = '0, r_ch = '0, clr_ch = '0;
    logic [DW-1:0]     w_data = '0;
    logic [DW-1:0]     r_data;
    logic              r_valid, fail;
    logic [NCH*DPW-1:0] cnt;
    logic [NCH-1:0]    empty, full, almost_empty, almost_full;

    int n_chk = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    logic [DW-1:0] stk [NCH][$];
    logic [DW-1:0] exp_data [$];
    st_t           exp_st [$];

    lifo_multi_ch #(.CH(NCH), .DEPTH(DEP), .DATA_W(DW), .AF_LVL(AF), .AE_LVL(AE)) dut (
        .clk(clk), .nrst(nrst),
        .w_req(w_req), .w_ch(w_ch), .w_data(w_data),
        .r_req(r_req), .r_ch(r_ch), .r_data(r_data), .r_valid(r_valid),
        .clr(clr), .clr_ch(clr_ch),
        .cnt(cnt), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full), .fail(fail)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: pop happens first, then push, then flush -- ordering alone
    // yields replace-top, push-only-on-empty and flush priority.
    task automatic step(input bit wr, input int wch, input logic [DW-1:0] wd,
                        input bit rr, input int rch, input bit cl, input int clch);
        bit  clv, wfl, rfl, pok, wok;
        st_t s;
        clv = cl && (clch < NCH);
        wfl = clv && (wch == clch);
        rfl = clv && (rch == clch);
        pok = 1'b0;
        wok = 1'b0;
        if (rr && rch < NCH && !rfl) pok = (stk[rch].size() > 0);
        if (pok) exp_data.push_back(stk[rch].pop_back());
        if (wr && wch < NCH && !wfl) wok = (stk[wch].size() < DEP);
        if (wok) stk[wch].push_back(wd);
        if (clv) stk[clch].delete();
        s.fail = (wr && !wfl && !wok) || (rr && !rfl && !pok);
        s.rv   = pok;
        s.cnt  = '0;
        for (int k = 0; k < NCH; k++) s.cnt[k*DPW +: DPW] = DPW'(stk[k].size());
        exp_st.push_back(s);
    endtask

    task automatic cyc(input bit wr, input int wch, input logic [DW-1:0] wd,
                       input bit rr, input int rch, input bit cl, input int clch);
        @(negedge clk);
        #1;
        w_req = wr;  w_ch = CW'(wch);  w_data = wd;
        r_req = rr;  r_ch = CW'(rch);
        clr = cl;    clr_ch = CW'(clch);
        step(wr, wch, wd, rr, rch, cl, clch);
    endtask

    task automatic idle();
        cyc(0, 0, '0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (nrst && mon_en) begin
            if (r_valid) begin
                if (exp_data.size() == 0) begin
                    chk("r_valid_unexpected", 1, 0);
                end else begin
                    chk("r_data", r_data, exp_data.pop_front());
                end
            end
            if (exp_st.size() > 0) begin
                st_t s;
                logic [NCH-1:0] ee, ef, eae, eaf;
                int c;
                s = exp_st.pop_front();
                for (int k = 0; k < NCH; k++) begin
                    c = int'(s.cnt[k*DPW +: DPW]);
                    ee[k]  = (c == 0);
                    ef[k]  = (c == DEP);
                    eae[k] = (c <= AE);
                    eaf[k] = (c >= AF);
                end
                chk("cnt", cnt, s.cnt);
                chk("fail", fail, s.fail);
                chk("r_valid", r_valid, s.rv);
                chk("empty", empty, ee);
                chk("full", full, ef);
                chk("almost_empty", almost_empty, eae);
                chk("almost_full", almost_full, eaf);
            end
        end
    end

    initial begin
        int wch, rch;
        nrst = 1'b0;
        #12;
        chk("rst_cnt", cnt, '0);
        chk("rst_r_data", r_data, '0);
        chk("rst_r_valid", r_valid, 0);
        chk("rst_fail", fail, 0);
        chk("rst_empty", empty, {NCH{1'b1}});
        chk("rst_ae", almost_empty, {NCH{1'b1}});
        chk("rst_full", full, '0);
        chk("rst_af", almost_full, '0);
        @(negedge clk);
        nrst = 1'b1;
        mon_en = 1'b1;

        // fill ch1 to full, one overflow
        for (int i = 0; i < 8; i++) cyc(1, 1, 32'hA0 + i, 0, 0, 0, 0);
        cyc(1, 1, 32'hBAD, 0, 0, 0, 0);
        // drain ch1, one underflow
        for (int i = 0; i < 9; i++) cyc(0, 0, '0, 1, 1, 0, 0);
        // replace top
        cyc(1, 1, 5, 0, 0, 0, 0);
        cyc(1, 1, 6, 0, 0, 0, 0);
        cyc(1, 1, 9, 1, 1, 0, 0);
        cyc(0, 0, '0, 1, 1, 0, 0);
        cyc(0, 0, '0, 1, 1, 0, 0);
        // independent channels
        cyc(1, 2, 32'h22, 0, 0, 0, 0);
        cyc(1, 0, 32'h11, 1, 2, 0, 0);
        // flush with competing push
        for (int i = 0; i < 3; i++) cyc(1, 3, 32'h30 + i, 0, 0, 0, 0);
        cyc(1, 3, 32'h3F, 1, 3, 1, 3);
        // empty channel same-cycle push+pop
        cyc(0, 0, '0, 0, 0, 1, 0);
        cyc(1, 0, 32'h33, 1, 0, 0, 0);
        // replace on a full channel
        for (int i = 0; i < 8; i++) cyc(1, 4, 32'h40 + i, 0, 0, 0, 0);
        cyc(1, 4, 32'h4F, 1, 4, 0, 0);
        // invalid channels and ignored flush
        cyc(1, 5, 32'h55, 0, 0, 0, 0);
        cyc(0, 0, '0, 1, 7, 0, 0);
        cyc(0, 0, '0, 0, 0, 1, 6);
        cyc(1, 6, 32'h66, 1, 5, 0, 0);
        idle();

        for (int i = 0; i < 1500; i++) begin
            int bias;
            bias = (i / 150) % 2;
            wch = ($urandom_range(0, 9) < 9) ? int'($urandom_range(0, NCH-1)) : int'($urandom_range(NCH, 7));
            rch = ($urandom_range(0, 9) < 9) ? int'($urandom_range(0, NCH-1)) : int'($urandom_range(NCH, 7));
            cyc(($urandom_range(0, 3) < 3 - 2*bias) || ($urandom_range(0, 3) == 0), wch, $urandom(),
                ($urandom_range(0, 3) < 1 + 2*bias), rch,
                ($urandom_range(0, 19) == 0), int'($urandom_range(0, 7)));
        end
        idle();
        idle();

        // asynchronous reset while a pop result is on the output
        cyc(1, 1, 32'h77, 0, 0, 0, 0);
        cyc(0, 0, '0, 1, 1, 0, 0);
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        chk("pre_rst_r_valid", r_valid, 1);
        #1;
        nrst = 1'b0;
        #1;
        chk("midrst_r_valid", r_valid, 0);
        chk("midrst_cnt", cnt, '0);
        chk("midrst_r_data", r_data, '0);
        chk("midrst_empty", empty, {NCH{1'b1}});
        w_req = 0; r_req = 0; clr = 0;
        @(negedge clk);
        #1;
        nrst = 1'b1;
        for (int k = 0; k < NCH; k++) stk[k].delete();
        exp_data.delete();
        exp_st.delete();
        mon_en = 1'b1;
        cyc(1, 0, 32'h55, 0, 0, 0, 0);
        cyc(1, 0, 32'h56, 1, 0, 0, 0);
        cyc(0, 0, '0, 1, 0, 0, 0);
        idle();
        idle();
        @(negedge clk);
        #2;
        chk("drain_data", exp_data.size(), 0);
        chk("drain_status", exp_st.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
